// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch stage: address/instruction widths,
// FSM encodings and the buffered fetch entry.
// Pure declarations, no logic.
package fetch_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    localparam u64 PCINIT     = 64'h0000_0000_8000_0000;
    localparam int BUF_DEPTH  = 2;
    localparam u64 INST_BYTES = 64'd4;

    localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_REQ   = 2'd1;
    localparam fetch_state_t ST_DRAIN = 2'd2;

    typedef struct packed {
        u64 pc;
        u32 inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry in-order buffer of fetched instructions toward decode.
// Latency: push in cycle N is visible at the head in cycle N+1.
// Backpressure: pop only when non-empty; push accepted if not full or popping; flush wins.
module fetch_skid_buf
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         push_vld,
    input  fetch_entry_t push_dat,
    input  logic         pop_rdy,
    input  logic         flush,
    output logic         head_vld,
    output fetch_entry_t head_dat,
    output logic [1:0]   count
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pop;
    logic         push_ok;

    assign pop     = pop_rdy && (count_q != 2'd0);
    assign push_ok = push_vld && ((count_q != BUF_FULL) || pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop})
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) head_d = push_dat;
                    else                 tail_d = push_dat;
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // With one entry the new data goes straight to the head slot
                    if (count_q == 2'd1) begin
                        head_d = push_dat;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_vld = (count_q != 2'd0);
    assign head_dat = head_q;
    assign count    = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues ibus requests, applies redirects.
// Latency: iresp_ok in cycle N gives out_valid in cycle N+1.
// Backpressure: requests issued only when a buffer slot is guaranteed; stalls go IDLE.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready,
    output logic [63:0] pc
);

    fetch_state_t state_q, state_d;
    u64           pc_q, pc_d;
    u64           stale_q, stale_d;
    logic         push;
    logic         flush;
    logic         pop;
    logic [1:0]   count;
    logic [1:0]   cnt_after_pop;
    fetch_entry_t push_dat;
    fetch_entry_t head_dat;

    assign pop           = out_valid && out_ready;
    assign cnt_after_pop = count - {1'b0, pop};
    assign push_dat      = '{pc: pc_q, inst: iresp_data};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stale_d = stale_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cnt_after_pop <= BUF_FULL - 2'd1) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (iresp_ok) begin
                    push    = 1'b1;
                    pc_d    = pc_q + INST_BYTES;
                    // Keep requesting only if the slot for the next response is free
                    state_d = (cnt_after_pop == 2'd0) ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (iresp_ok) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            flush = 1'b1;
            push  = 1'b0;
            pc_d  = redirect_pc;
            // An outstanding request must complete on its original address first
            if (state_q == ST_REQ && !iresp_ok) begin
                state_d = ST_DRAIN;
                stale_d = pc_q;
            end else if (state_q == ST_DRAIN && !iresp_ok) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pc_q    <= PCINIT;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
        end
    end

    fetch_skid_buf u_buf (
        .clk      (clk),
        .resetn   (resetn),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_rdy  (out_ready),
        .flush    (flush),
        .head_vld (out_valid),
        .head_dat (head_dat),
        .count    (count)
    );

    assign ireq_valid = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign ireq_addr  = (state_q == ST_DRAIN) ? stale_q : pc_q;
    assign out_pc     = head_dat.pc;
    assign out_inst   = head_dat.inst;
    assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus queues expected ibus addresses
// and decode entries; independent monitors pop and compare on each handshake.
module tb_fetch_ctrl;

    localparam logic [63:0] PC0 = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [63:0] pc;

    logic        resp_en;
    logic        prev_vld = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_resp = 0;
    logic [63:0] addr_q[$];
    logic [63:0] out_q[$];
    logic [63:0] mon_e;

    fetch_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_ok       (iresp_ok),
        .iresp_data     (iresp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready),
        .pc             (pc)
    );

    always #5 clk = ~clk;

    // ibus model: answers a request once it has been held for at least one cycle
    assign iresp_ok   = resp_en && ireq_valid && prev_vld;
    assign iresp_data = ireq_addr[31:0] ^ 32'h1357_9BDF;
    always @(posedge clk) prev_vld <= resetn && ireq_valid;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitors: ibus completions and decode handshakes
    always @(negedge clk) begin
        if (!resetn) begin
            n_resp = 0;
        end else begin
            if (ireq_valid && iresp_ok) begin
                n_resp++;
                if (addr_q.size() > 0) begin
                    mon_e = addr_q.pop_front();
                    check("req_addr", ireq_addr, mon_e);
                end
            end
            if (out_valid && out_ready && !redirect_valid && out_q.size() > 0) begin
                mon_e = out_q.pop_front();
                check("out_pc", out_pc, mon_e);
                check("out_inst", {32'h0, out_inst}, {32'h0, inst_of(mon_e)});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy, input logic en);
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        out_ready      = rdy;
        resp_en        = en;
        @(posedge clk);
        samp();
        check("rst_ireq_valid", ireq_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_inst", out_inst, 64'h0);
        check("rst_pc", pc, PC0);
        cyc();
        resetn = 1'b1;
        cyc();
    endtask

    task automatic end_test(input string name);
        check({name, "_addr_left"}, addr_q.size(), 0);
        check({name, "_out_left"}, out_q.size(), 0);
        addr_q.delete();
        out_q.delete();
    endtask

    initial begin
        int w;
        int gaps;
        resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b0; resp_en = 1'b0;

        // 1: streaming fetch with decode always ready
        do_reset(1'b1, 1'b1);
        addr_q = {PC0, PC0 + 64'd4, PC0 + 64'd8, PC0 + 64'd12};
        out_q  = {PC0, PC0 + 64'd4, PC0 + 64'd8, PC0 + 64'd12};
        samp();
        check("t1_first_vld", ireq_valid, 1'b1);
        check("t1_first_addr", ireq_addr, PC0);
        w = 0;
        while (!out_valid && w < 10) begin samp(); w++; end
        check("t1_fill", out_valid, 1'b1);
        gaps = 0;
        repeat (5) begin samp(); if (!out_valid) gaps++; end
        check("t1_no_gap", gaps, 0);
        cyc();
        end_test("t1");

        // 2: decode stalled, buffer fills to two and requests stop
        do_reset(1'b0, 1'b1);
        addr_q = {PC0, PC0 + 64'd4};
        out_q  = {PC0, PC0 + 64'd4};
        repeat (10) cyc();
        samp();
        check("t2_req_idle", ireq_valid, 1'b0);
        check("t2_out_vld", out_valid, 1'b1);
        check("t2_head_pc", out_pc, PC0);
        check("t2_resp_cnt", n_resp, 2);
        cyc();
        out_ready = 1'b1;
        repeat (3) cyc();
        end_test("t2");

        // 3: redirect while a request is outstanding
        do_reset(1'b1, 1'b0);
        addr_q = {PC0, 64'h8000_1000, 64'h8000_1004};
        out_q  = {64'h8000_1000, 64'h8000_1004};
        cyc();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        cyc();
        redirect_valid = 1'b0;
        samp();
        check("t3_stale_addr", ireq_addr, PC0);
        check("t3_pc", pc, 64'h8000_1000);
        cyc(); cyc();
        resp_en = 1'b1;
        cyc();
        samp();
        check("t3_no_stale", out_valid, 1'b0);
        check("t3_new_addr", ireq_addr, 64'h8000_1000);
        repeat (4) cyc();
        end_test("t3");

        // 4: redirect coincident with a response and a pop
        do_reset(1'b1, 1'b1);
        addr_q = {PC0, PC0 + 64'd4, PC0 + 64'd8, 64'h4000_0000, 64'h4000_0004};
        out_q  = {PC0, 64'h4000_0000, 64'h4000_0004};
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1; redirect_pc = 64'h4000_0000;
        samp();
        check("t4_pop_vld", out_valid, 1'b1);
        check("t4_resp_vld", iresp_ok, 1'b1);
        cyc();
        redirect_valid = 1'b0;
        samp();
        check("t4_flushed", out_valid, 1'b0);
        check("t4_new_addr", ireq_addr, 64'h4000_0000);
        repeat (3) cyc();
        end_test("t4");

        // 5: two redirects inside one drain, last wins
        do_reset(1'b1, 1'b0);
        addr_q = {PC0, 64'h200, 64'h204};
        out_q  = {64'h200, 64'h204};
        cyc();
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        cyc();
        redirect_pc = 64'h200;
        cyc();
        redirect_valid = 1'b0; resp_en = 1'b1;
        samp();
        check("t5_drain_addr", ireq_addr, PC0);
        check("t5_pc", pc, 64'h200);
        cyc();
        samp();
        check("t5_new_addr", ireq_addr, 64'h200);
        repeat (3) cyc();
        end_test("t5");

        // 6: PC wrap-around, then reset in the middle of a drain
        do_reset(1'b1, 1'b0);
        addr_q = {PC0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        out_q  = {64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        cyc();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0; resp_en = 1'b1;
        cyc(); cyc();
        samp();
        check("t6_wrap_addr", ireq_addr, 64'h0);
        check("t6_wrap_pc", pc, 64'h0);
        repeat (3) cyc();
        end_test("t6");
        resp_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h300;
        cyc();
        redirect_valid = 1'b0;
        samp();
        check("t6_drain_vld", ireq_valid, 1'b1);
        check("t6_drain_addr", ireq_addr, 64'hC);
        check("t6_drain_pc", pc, 64'h300);
        do_reset(1'b1, 1'b1);
        samp();
        check("t6_restart_vld", ireq_valid, 1'b1);
        check("t6_restart_addr", ireq_addr, PC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
